// File: rtl/piso_pkg.sv
// Shared definitions for the 16-bit serial register path (transmitter and receiver).
package piso_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic {
    StIdle,
    StShift
  } state_e;

endpackage

// File: rtl/bit_counter.sv
// Bit-position counter with clear, enable and a terminal flag at WIDTH-1; never wraps.
module bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CntW = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [CntW-1:0] count,
  output logic            terminal
);

  localparam logic [CntW-1:0] MaxCount = CntW'(WIDTH - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !terminal) begin
      count_q <= count_q + CntW'(1);
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == MaxCount);

endmodule

// File: rtl/piso16.sv
// Parallel-in, serial-out transmitter with valid/ready handshakes on both the load and serial sides.
module piso16
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt;
  logic             cnt_last;
  logic             shift_fire, last_fire, load_fire;

  assign busy       = (state_q == StShift);
  assign sout_valid = busy;
  assign sout_last  = busy & cnt_last;
  assign shift_fire = busy & sout_ready;
  assign last_fire  = shift_fire & cnt_last;
  // Only combinational input-to-output path: lets a new word follow the last bit with no gap.
  assign load_ready = ~busy | (sout_last & sout_ready);
  assign load_fire  = load_valid & load_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_valid) state_d = StShift;
      StShift: if (last_fire && !load_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (load_fire) begin
      shreg_q <= d;
    end else if (shift_fire) begin
      if (MSB_FIRST) shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
      else           shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
    end
  end

  assign sout = busy & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (load_fire | last_fire),
    .en       (shift_fire),
    .count    (cnt),
    .terminal (cnt_last)
  );

endmodule

// File: tb/tb_piso16.sv
// Self-checking bench: MSB-first and LSB-first instances driven in lockstep against a word/index model.
module tb_piso16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d = '0;
  logic        load_valid = 1'b0;
  logic        sout_ready = 1'b0;

  logic m_load_ready, m_sout, m_sout_valid, m_sout_last, m_busy;
  logic l_load_ready, l_sout, l_sout_valid, l_sout_last, l_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the word in flight and the index of the bit currently presented.
  bit          mdl_active = 1'b0;
  int          mdl_idx = 0;
  logic [15:0] mdl_word = '0;

  // Receiver-side reassembly of each DUT's accepted bits.
  logic [15:0] rx_m = '0;
  logic [15:0] rx_l = '0;
  int          rx_n = 0;
  int          valid_cnt = 0;

  always #5 clk = ~clk;

  piso16 #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .load_valid (load_valid),
    .load_ready (m_load_ready),
    .sout       (m_sout),
    .sout_valid (m_sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (m_sout_last),
    .busy       (m_busy)
  );

  piso16 #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .load_valid (load_valid),
    .load_ready (l_load_ready),
    .sout       (l_sout),
    .sout_valid (l_sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (l_sout_last),
    .busy       (l_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic exp_last, exp_lr, exp_m, exp_l;
    exp_last = mdl_active && (mdl_idx == 15);
    exp_lr   = !mdl_active || (exp_last && sout_ready);
    exp_m    = mdl_active ? mdl_word[15 - mdl_idx] : 1'b0;
    exp_l    = mdl_active ? mdl_word[mdl_idx] : 1'b0;
    check_eq("msb_sout", 32'(m_sout), 32'(exp_m));
    check_eq("msb_sout_valid", 32'(m_sout_valid), 32'(mdl_active));
    check_eq("msb_sout_last", 32'(m_sout_last), 32'(exp_last));
    check_eq("msb_load_ready", 32'(m_load_ready), 32'(exp_lr));
    check_eq("msb_busy", 32'(m_busy), 32'(mdl_active));
    check_eq("lsb_sout", 32'(l_sout), 32'(exp_l));
    check_eq("lsb_sout_valid", 32'(l_sout_valid), 32'(mdl_active));
    check_eq("lsb_sout_last", 32'(l_sout_last), 32'(exp_last));
    check_eq("lsb_load_ready", 32'(l_load_ready), 32'(exp_lr));
    check_eq("lsb_busy", 32'(l_busy), 32'(mdl_active));
  endtask

  task automatic model_reset();
    mdl_active = 1'b0;
    mdl_idx    = 0;
    mdl_word   = '0;
    rx_m       = '0;
    rx_l       = '0;
    rx_n       = 0;
  endtask

  // Drive one cycle's inputs at the falling edge, check, then advance the model across the rising edge.
  task automatic cycle(input logic lv, input logic [15:0] dv, input logic sr);
    logic exp_lr, acc, ld;
    @(negedge clk);
    load_valid = lv;
    d          = dv;
    sout_ready = sr;
    #1;
    compare_outputs();
    if (m_sout_valid) valid_cnt++;
    if (m_sout_valid && sout_ready) begin
      rx_m = {rx_m[14:0], m_sout};
      rx_l = {l_sout, rx_l[15:1]};
      rx_n++;
      if (m_sout_last) begin
        check_eq("rx_bits", 32'(rx_n), 32'd16);
        check_eq("rx_msb_word", 32'(rx_m), 32'(mdl_word));
        check_eq("rx_lsb_word", 32'(rx_l), 32'(mdl_word));
        rx_n = 0;
      end
    end
    exp_lr = !mdl_active || ((mdl_idx == 15) && sr);
    acc    = mdl_active && sr;
    ld     = lv && exp_lr;
    if (acc) begin
      if (mdl_idx == 15) mdl_active = 1'b0;
      else mdl_idx++;
    end
    if (ld) begin
      mdl_word   = dv;
      mdl_idx    = 0;
      mdl_active = 1'b1;
      rx_n       = 0;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    cycle(1'b1, w, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, 1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    #1;
    compare_outputs();
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 16'h0, 1'b1);

    // Alternating patterns, both bit orders
    send_word(16'hAAAA);
    cycle(1'b0, 16'h0, 1'b1);
    send_word(16'h5555);
    cycle(1'b0, 16'h0, 1'b0);

    // Stalls: sout_ready pattern 1,0,0,1 repeating
    cycle(1'b1, 16'hF0F0, 1'b1);
    for (int i = 0; i < 70; i++) cycle(1'b0, 16'h0, (i % 4 == 0) || (i % 4 == 3));

    // Back-to-back with load_valid held high
    valid_cnt = 0;
    cycle(1'b1, 16'hAAAA, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'h5555, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, 1'b1);
    check_eq("b2b_valid_cycles", 32'(valid_cnt), 32'd32);
    cycle(1'b0, 16'h0, 1'b1);

    // Asynchronous reset at bit 7
    cycle(1'b1, 16'hF0F0, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 16'h0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs();
    @(negedge clk);
    rst = 1'b0;
    send_word(16'h1234);
    cycle(1'b0, 16'h0, 1'b1);

    // Load pulse mid-word is ignored
    cycle(1'b1, 16'hC3A5, 1'b1);
    for (int i = 0; i < 16; i++) cycle(i == 5, 16'hFFFF, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    check_eq("no_second_word", 32'(m_busy), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) == 0), 16'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/piso16.md
# piso16

Parallel-in, serial-out transmitter that accepts a 16-bit word through a valid/ready load handshake and shifts it out one bit per accepted cycle. It is the sending end for the team's 16-bit register path: the word a register holds is serialized here and reassembled downstream by a serial-in, parallel-out receiver. It sits between the parallel datapath and a single-wire serial link that has its own valid/ready flow control.

## Interface
- WIDTH, 16, word width in bits (≥2)
- MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- d  input  WIDTH  parallel word to send
- load_valid  input  1  d is valid and offered for transmission
- load_ready  output  1  block can accept a word this cycle
- sout  output  1  current serial bit
- sout_valid  output  1  sout carries a valid bit
- sout_ready  input  1  downstream accepts sout this cycle
- sout_last  output  1  current bit is the final bit of the word
- busy  output  1  a word is being transmitted

## Operation
- Two states: IDLE and SHIFT.
- IDLE: load_ready=1, sout_valid=0. A rising edge with load_valid=1 captures d into the shift register, clears the bit counter to 0, and moves to SHIFT.
- SHIFT: sout_valid=1. sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. A rising edge with sout_ready=1 shifts shreg one position toward the output end (zero-fill) and increments the counter. With sout_ready=0, all state holds, and sout and sout_last stay stable.
- sout_last = 1 when counter == WIDTH-1 in SHIFT.
- The last bit is accepted when sout_last and sout_ready are both 1 at an edge:
  - If load_valid=1 at that edge: new d is loaded, counter cleared, and the state stays SHIFT (back-to-back, no gap).
  - Otherwise: go to IDLE.
- load_ready = (state==IDLE) | (sout_last & sout_ready). This is combinational from sout_ready, and it is the only combinational input-to-output path.
- load_valid while load_ready=0 is ignored; d is not sampled.
- Counter width is $clog2(WIDTH) and never wraps past WIDTH-1.
- busy = (state==SHIFT).
- Reset is asynchronous and can occur at any time. It aborts any word in flight, discards remaining bits, and emits no partial last.

## Timing
- Reset values: state=IDLE, shreg=0, counter=0, sout=0, sout_valid=0, sout_last=0, busy=0, load_ready=1.
- Latency: the first bit is valid on the cycle after the load edge.
- With sout_ready held at 1, a word occupies exactly WIDTH cycles of sout_valid.
- Back-to-back words: the first bit of word N+1 appears the cycle after the last bit of word N, with zero idle cycles.
- All outputs except load_ready are registered or decoded from registers only.

## Structure
- Shared package piso_pkg:
  - state typedef (IDLE, SHIFT)
  - default WIDTH constant, shared with the receiver
- One natural sub-module: bit_counter, a $clog2(WIDTH)-bit counter with clear, enable, and a terminal flag (count == WIDTH-1). The receiver reuses it.
- The shift register and FSM stay in piso16.

## Test plan
- Reset, then load 16'hAAAA with MSB_FIRST=1 and sout_ready=1 -> sout = 1,0,1,0,… for 16 cycles; sout_last only on cycle 16; then IDLE with load_ready=1.
- Load 16'h5555 with MSB_FIRST=0 -> the first bit out is 1 and the sequence is bit 0 to bit 15; a receiver model reassembles 16'h5555.
- Load 16'hF0F0 and toggle sout_ready 1,0,0,1,… -> sout holds during stalls; exactly 16 accepted bits; the reassembled word is 16'hF0F0.
- Back-to-back: load_valid held high with 16'hAAAA then 16'h5555 -> 32 consecutive valid bits, with sout_last on bits 16 and 32 and no gap cycle.
- Assert rst at bit 7 of 16'hF0F0 -> all outputs go to reset values immediately (asynchronously). After release, loading 16'h1234 sends a clean 16'h1234.
- load_valid pulse while busy, before the last bit -> ignored; the current word completes unchanged and no second word is sent.
